// File: rtl/mem_bus_initiator.sv
// Peripheral bus master: DEPTH-entry in-order request FIFO feeding a one-at-a-time ABUS/DBUS/WE sequencer.
// Bus starts the cycle after an entry is queued; REQ_READY=!full. MEM_BUS_ALIGN_CHECK_EN: misaligned requests become error responses.
module mem_bus_initiator #(
  parameter int unsigned DEPTH     = 2,
  parameter int unsigned RD_LAT    = 1,
  parameter logic [31:0] IDLE_ADDR = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        INIT,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic        REQ_WE,
  input  logic [31:0] REQ_ADDR,
  input  logic [31:0] REQ_WDATA,
  output logic        RSP_VALID,
  output logic [31:0] RSP_RDATA,
  output logic        RSP_ERR,
  output logic        BUSY,
  output logic [31:0] ABUS,
  inout  wire  [31:0] DBUS,
  output logic        WE
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

  req_t        mem_q [DEPTH];
  req_t        mem_d [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] cur_addr_q, cur_addr_d;
  logic [31:0] cur_wdata_q, cur_wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        init_done_q, init_done_d;
  logic        empty, full, push, pop;
  req_t        head;
`ifdef MEM_BUS_ALIGN_CHECK_EN
  logic        err_q, err_d;
`endif

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  // Ready is held low until the first edge after INIT drops.
  assign REQ_READY = init_done_q & ~full;
  assign push      = REQ_VALID & REQ_READY;

  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    cur_addr_d  = cur_addr_q;
    cur_wdata_d = cur_wdata_q;
    rdata_d     = rdata_q;
    init_done_d = 1'b1;
    pop         = 1'b0;
`ifdef MEM_BUS_ALIGN_CHECK_EN
    err_d       = err_q;
`endif

    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = '{we: REQ_WE, addr: REQ_ADDR, wdata: REQ_WDATA};
      wr_ptr_d = wr_ptr_q + 1'b1;
    end

    case (state_q)
      READ: begin
        if (cnt_q == CW'(RD_LAT - 1)) begin
          rdata_d = DBUS;
          cnt_d   = '0;
          state_d = RESP;
`ifdef MEM_BUS_ALIGN_CHECK_EN
          err_d   = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        // IDLE, the single WRITE cycle and RESP may all launch the next entry.
        state_d = IDLE;
        if (!empty) begin
          pop         = 1'b1;
          cur_addr_d  = head.addr;
          cur_wdata_d = head.wdata;
          cnt_d       = '0;
          state_d     = head.we ? WRITE : READ;
`ifdef MEM_BUS_ALIGN_CHECK_EN
          if (head.addr[1:0] != 2'b00) begin
            state_d = RESP;
            err_d   = 1'b1;
          end
`endif
        end
      end
    endcase

    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
  end

  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge CLK) begin
    if (INIT) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      cur_addr_q  <= '0;
      cur_wdata_q <= '0;
      rdata_q     <= '0;
      init_done_q <= 1'b0;
`ifdef MEM_BUS_ALIGN_CHECK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cur_addr_q  <= cur_addr_d;
      cur_wdata_q <= cur_wdata_d;
      rdata_q     <= rdata_d;
      init_done_q <= init_done_d;
`ifdef MEM_BUS_ALIGN_CHECK_EN
      err_q       <= err_d;
`endif
    end
  end

  assign ABUS      = ((state_q == WRITE) || (state_q == READ)) ? cur_addr_q : IDLE_ADDR;
  assign WE        = (state_q == WRITE);
  assign DBUS      = (state_q == WRITE) ? cur_wdata_q : 32'bz;
  assign RSP_VALID = (state_q == RESP);
  assign RSP_RDATA = rdata_q;
  assign BUSY      = ~empty | (state_q != IDLE);
`ifdef MEM_BUS_ALIGN_CHECK_EN
  assign RSP_ERR   = err_q & (state_q == RESP);
`else
  assign RSP_ERR   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_initiator.sv
// Directed bench for mem_bus_initiator: a RD_LAT=1 instance with a word-memory responder and a RD_LAT=3 instance for INIT abort.
// Responders drive DBUS whenever WE=0, so an initiator that fails to release the bus corrupts the observed value.
module tb_mem_bus_initiator;
  localparam logic [31:0] IDLE_PAT = 32'hA5A5_5A5A;
  localparam logic [31:0] RD_FILL  = 32'h5A5A_A5A5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic        init, req_valid, req_we;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, rsp_valid, rsp_err, busy, we;
  logic [31:0] rsp_rdata, abus;
  wire  [31:0] dbus;

  logic        init3, req3_valid, req3_we;
  logic [31:0] req3_addr, req3_wdata;
  logic        req3_ready, rsp3_valid, rsp3_err, busy3, we3;
  logic [31:0] rsp3_rdata, abus3;
  wire  [31:0] dbus3;

  mem_bus_initiator #(.DEPTH(2), .RD_LAT(1), .IDLE_ADDR(32'h0)) u_dut (
    .CLK(clk), .INIT(init), .REQ_VALID(req_valid), .REQ_READY(req_ready),
    .REQ_WE(req_we), .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata),
    .RSP_VALID(rsp_valid), .RSP_RDATA(rsp_rdata), .RSP_ERR(rsp_err),
    .BUSY(busy), .ABUS(abus), .DBUS(dbus), .WE(we)
  );

  mem_bus_initiator #(.DEPTH(2), .RD_LAT(3), .IDLE_ADDR(32'h0)) u_dut3 (
    .CLK(clk), .INIT(init3), .REQ_VALID(req3_valid), .REQ_READY(req3_ready),
    .REQ_WE(req3_we), .REQ_ADDR(req3_addr), .REQ_WDATA(req3_wdata),
    .RSP_VALID(rsp3_valid), .RSP_RDATA(rsp3_rdata), .RSP_ERR(rsp3_err),
    .BUSY(busy3), .ABUS(abus3), .DBUS(dbus3), .WE(we3)
  );

  // Bus-model word memory decodes {addr[31], addr[8:2]}.
  logic [31:0] bus_mem [256];
  function automatic logic [7:0] mem_idx(input logic [31:0] a);
    return {a[31], a[8:2]};
  endfunction

  assign dbus  = we ? 32'bz : ((abus != 32'h0) ? bus_mem[mem_idx(abus)] : IDLE_PAT);
  assign dbus3 = we3 ? 32'bz : 32'h1234_5678;

  always @(posedge clk) begin
    if (init) begin
      for (int j = 0; j < 256; j++) bus_mem[j] <= 32'h0;
    end else if (we) begin
      bus_mem[mem_idx(abus)] <= dbus;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t        vecs [10];
  logic [31:0] last_rd_val;

  task automatic run_vec(input vec_t v, input int i);
    int  we_cyc, rd_cyc, rsp_n, last_rd, rsp_at;
    bit  done;
    logic [31:0] got;
    we_cyc = 0; rd_cyc = 0; rsp_n = 0; last_rd = -1; rsp_at = -1; done = 0; got = '0;
    chk($sformatf("v%0d_ready", i), 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = v.we; req_addr = v.addr; req_wdata = v.wdata;
    step();
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    for (int k = 0; k < 20; k++) begin
      if (we) begin
        we_cyc++;
        chk($sformatf("v%0d_wr_abus", i), abus, v.addr);
        chk($sformatf("v%0d_wr_dbus", i), dbus, v.wdata);
      end
      if (!we && abus != 32'h0) begin
        rd_cyc++;
        last_rd = k;
        chk($sformatf("v%0d_rd_abus", i), abus, v.addr);
        chk($sformatf("v%0d_rd_dbus", i), dbus, v.exp_rdata);
      end
      if (rsp_valid) begin
        rsp_n++;
        rsp_at = k;
        got = rsp_rdata;
        chk($sformatf("v%0d_rsp_err", i), 32'(rsp_err), 32'd0);
      end
      if (!busy) begin
        done = 1;
        break;
      end
      step();
    end
    chk($sformatf("v%0d_finished", i), 32'(done), 32'd1);
    if (v.we) begin
      chk($sformatf("v%0d_we_cycles", i), 32'(we_cyc), 32'd1);
      chk($sformatf("v%0d_no_rsp", i), 32'(rsp_n), 32'd0);
      chk($sformatf("v%0d_no_rd", i), 32'(rd_cyc), 32'd0);
      chk($sformatf("v%0d_model_reg", i), bus_mem[mem_idx(v.addr)], v.wdata);
      chk($sformatf("v%0d_rdata_hold", i), rsp_rdata, last_rd_val);
    end else begin
      chk($sformatf("v%0d_no_we", i), 32'(we_cyc), 32'd0);
      chk($sformatf("v%0d_rd_cycles", i), 32'(rd_cyc), 32'd1);
      chk($sformatf("v%0d_rsp_count", i), 32'(rsp_n), 32'd1);
      chk($sformatf("v%0d_rsp_timing", i), 32'(rsp_at), 32'(last_rd + 1));
      chk($sformatf("v%0d_rdata", i), got, v.exp_rdata);
      chk($sformatf("v%0d_rdata_hold", i), rsp_rdata, v.exp_rdata);
      last_rd_val = v.exp_rdata;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b1, 32'hFFFF_F104, 32'h0000_03E8, 32'h0};
    vecs[1] = '{1'b0, 32'hFFFF_F104, RD_FILL,       32'h0000_03E8};
    vecs[2] = '{1'b1, 32'h0000_01F8, 32'hDEAD_BEEF, 32'h0};
    vecs[3] = '{1'b0, 32'h0000_01F8, RD_FILL,       32'hDEAD_BEEF};
    vecs[4] = '{1'b0, 32'hFFFF_F104, RD_FILL,       32'h0000_03E8};
    vecs[5] = '{1'b1, 32'h0000_01F8, 32'h0000_0000, 32'h0};
    vecs[6] = '{1'b0, 32'h0000_01F8, RD_FILL,       32'h0000_0000};
    vecs[7] = '{1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'h0};
    vecs[8] = '{1'b0, 32'hFFFF_FFFC, RD_FILL,       32'hFFFF_FFFF};
    vecs[9] = '{1'b0, 32'h0000_0104, RD_FILL,       32'h0000_0000};
    last_rd_val = 32'h0;

    init = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    init3 = 1'b1; req3_valid = 1'b0; req3_we = 1'b0; req3_addr = '0; req3_wdata = '0;
    step();
    step();
    chk("init_ready_low", 32'(req_ready), 32'd0);
    init = 1'b0; init3 = 1'b0;
    step();
    chk("rst_ready",     32'(req_ready), 32'd1);
    chk("rst_abus",      abus, 32'h0);
    chk("rst_we",        32'(we), 32'd0);
    chk("rst_dbus_free", dbus, IDLE_PAT);
    chk("rst_busy",      32'(busy), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rdata",     rsp_rdata, 32'h0);
    chk("rst_rsp_err",   32'(rsp_err), 32'd0);

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // Read, then two writes fill the FIFO while the read is in flight, then a read-after-write.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'hFFFF_F104; req_wdata = RD_FILL;
    step();
    chk("full_p1_abus_idle", abus, 32'h0);
    chk("full_p1_busy", 32'(busy), 32'd1);
    req_we = 1'b1; req_addr = 32'h0000_0100; req_wdata = 32'h0000_000A;
    step();
    chk("full_p2_rd_abus", abus, 32'hFFFF_F104);
    chk("full_p2_we", 32'(we), 32'd0);
    req_we = 1'b1; req_addr = 32'h0000_0104; req_wdata = 32'h0000_000B;
    step();
    chk("full_p3_ready_low", 32'(req_ready), 32'd0);
    chk("full_p3_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("full_p3_rdata", rsp_rdata, 32'h0000_03E8);
    req_we = 1'b0; req_addr = 32'h0000_0100; req_wdata = RD_FILL;
    step();
    chk("full_p4_we", 32'(we), 32'd1);
    chk("full_p4_abus", abus, 32'h0000_0100);
    chk("full_p4_dbus", dbus, 32'h0000_000A);
    chk("full_p4_ready", 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
    chk("full_p5_we", 32'(we), 32'd1);
    chk("full_p5_abus", abus, 32'h0000_0104);
    chk("full_p5_dbus", dbus, 32'h0000_000B);
    step();
    chk("full_p6_we", 32'(we), 32'd0);
    chk("full_p6_abus", abus, 32'h0000_0100);
    chk("full_p6_dbus", dbus, 32'h0000_000A);
    chk("full_p6_no_rsp", 32'(rsp_valid), 32'd0);
    step();
    chk("full_p7_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("full_p7_rdata", rsp_rdata, 32'h0000_000A);
    chk("full_p7_abus_idle", abus, 32'h0);
    step();
    chk("full_p8_busy", 32'(busy), 32'd0);
    chk("full_p8_rsp_valid", 32'(rsp_valid), 32'd0);
    last_rd_val = 32'h0000_000A;

    // INIT during the second of three READ cycles, with a second read still queued.
    req3_valid = 1'b1; req3_we = 1'b0; req3_addr = 32'h0000_0040; req3_wdata = RD_FILL;
    step();
    req3_addr = 32'h0000_0044;
    step();
    req3_valid = 1'b0;
    chk("abort_rd_abus", abus3, 32'h0000_0040);
    chk("abort_rd_we", 32'(we3), 32'd0);
    step();
    chk("abort_rd_abus_hold", abus3, 32'h0000_0040);
    init3 = 1'b1;
    step();
    chk("abort_abus", abus3, 32'h0);
    chk("abort_we", 32'(we3), 32'd0);
    chk("abort_busy", 32'(busy3), 32'd0);
    chk("abort_ready_low", 32'(req3_ready), 32'd0);
    init3 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      chk($sformatf("abort_no_rsp_%0d", k), 32'(rsp3_valid), 32'd0);
      chk($sformatf("abort_idle_%0d", k), abus3, 32'h0);
    end
    chk("abort_ready", 32'(req3_ready), 32'd1);
    chk("abort_flushed", 32'(busy3), 32'd0);

`ifdef MEM_BUS_ALIGN_CHECK_EN
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'hFFFF_F102; req_wdata = RD_FILL;
    step();
    req_valid = 1'b0;
    chk("mis_rd_idle_abus", abus, 32'h0);
    step();
    chk("mis_rd_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("mis_rd_rsp_err", 32'(rsp_err), 32'd1);
    chk("mis_rd_rdata", rsp_rdata, last_rd_val);
    chk("mis_rd_abus", abus, 32'h0);
    chk("mis_rd_we", 32'(we), 32'd0);
    step();
    chk("mis_rd_busy", 32'(busy), 32'd0);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0000_01F2; req_wdata = 32'h0000_0055;
    step();
    req_valid = 1'b0;
    step();
    chk("mis_wr_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("mis_wr_rsp_err", 32'(rsp_err), 32'd1);
    chk("mis_wr_we", 32'(we), 32'd0);
    chk("mis_wr_abus", abus, 32'h0);
`else
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0000_01F2; req_wdata = 32'h0000_0055;
    step();
    req_valid = 1'b0;
    step();
    chk("mis_wr_we", 32'(we), 32'd1);
    chk("mis_wr_abus", abus, 32'h0000_01F2);
    chk("mis_wr_dbus", dbus, 32'h0000_0055);
    step();
    chk("mis_wr_no_rsp", 32'(rsp_valid), 32'd0);
    chk("mis_wr_rsp_err", 32'(rsp_err), 32'd0);
    chk("mis_wr_busy", 32'(busy), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_bus_initiator.md
Name: mem_bus_initiator

Overview:
- Bus-master end of the memory-mapped peripheral bus (ABUS/DBUS/WE). Sits between the processor memory stage and the peripherals (timer, switches, LEDs, etc.).
- Accepts word read/write requests from the core through a valid/ready handshake. Buffers them in a small in-order FIFO, then drives ABUS/WE/DBUS one transaction at a time.
- Captures read data from responders and returns it to the core with a one-cycle valid pulse.

Parameters:
- DEPTH, 2, request FIFO entries; power of 2, minimum 2.
- RD_LAT, 1, bus cycles a read address is held before DBUS is sampled; minimum 1.
- IDLE_ADDR, 32'h00000000, value driven on ABUS when no transaction is active.

Ports:
- CLK  in  1  system clock.
- INIT  in  1  synchronous active-high reset.
- REQ_VALID  in  1  core presents a request.
- REQ_READY  out  1  FIFO can accept a request.
- REQ_WE  in  1  1 = write, 0 = read.
- REQ_ADDR  in  32  byte address.
- REQ_WDATA  in  32  write data.
- RSP_VALID  out  1  one-cycle pulse; RSP_RDATA is valid.
- RSP_RDATA  out  32  read data.
- RSP_ERR  out  1  qualifies RSP_VALID (optional feature only; otherwise tied 0).
- BUSY  out  1  FIFO non-empty or bus transaction active.
- ABUS  out  32  bus address.
- DBUS  inout  32  bus data.
- WE  out  1  bus write enable.

Behaviour:
- Clock and reset: one clock, CLK. INIT is synchronous and active-high.
- Values while/after INIT:
  - REQ_READY=1 after the first non-INIT edge (0 while INIT is high).
  - RSP_VALID=0, RSP_RDATA=0, RSP_ERR=0, BUSY=0.
  - ABUS=IDLE_ADDR, WE=0, DBUS released (high-Z).
  - FIFO empty, FSM in IDLE.
- Handshake:
  - A request is accepted on a posedge with REQ_VALID & REQ_READY; {WE, ADDR, WDATA} is pushed.
  - REQ_READY = !full. There is no same-cycle bypass when full, even if a pop occurs that cycle.
  - REQ_* inputs are don't-care when REQ_VALID=0.
- FSM: IDLE, WRITE, READ, RESP.
  - IDLE: if the FIFO is non-empty, pop the head and go to WRITE (WE=1) or READ (WE=0). An entry pushed in cycle N can start bus activity in cycle N+1 at the earliest.
  - WRITE: exactly one cycle. ABUS=addr, WE=1, DBUS driven with wdata; the responder latches at the closing edge. Then return to IDLE, or pop the next entry directly if the FIFO is non-empty (back-to-back writes, no bubble). Writes are posted and produce no response.
  - READ: ABUS=addr, WE=0, DBUS released for RD_LAT cycles (internal counter 0..RD_LAT-1). DBUS is sampled into RSP_RDATA on the edge closing the last cycle. Then go to RESP.
  - RESP: RSP_VALID=1 for one cycle and RSP_RDATA holds the sampled value. ABUS returns to IDLE_ADDR; the next FIFO entry may be popped in this same cycle (bus starts next cycle).
- Read-to-read throughput: RD_LAT+1 cycles per read.
- RSP_RDATA holds its value until the next read completes.
- DBUS is driven only in WRITE. There is never a cycle with WE=1 and DBUS released.
- Ordering: strictly in request order. A read issued after a write to the same address observes the written value.
- FIFO pointers: log2(DEPTH)+1 bits. Full = MSBs differ and the rest are equal; wrap-around is natural.
- Push and pop in the same cycle keep the count unchanged; legal when the FIFO is neither full (push blocked) nor empty.
- BUSY = !empty | (state != IDLE).
- INIT mid-operation: the FIFO is flushed and any in-flight read is dropped (no RSP_VALID). Bus returns to idle values on that edge; WE never stays high past the INIT edge.

Optional Feature:
- Macro: MEM_BUS_ALIGN_CHECK_EN.
- With the macro defined:
  - A popped request with ADDR[1:0] != 0 is never placed on the bus; ABUS stays IDLE_ADDR and WE stays 0 that cycle.
  - FSM goes directly to RESP with RSP_VALID=1, RSP_ERR=1, RSP_RDATA unchanged. This applies to both reads and writes, so misaligned writes also produce a response.
  - Aligned requests behave as above with RSP_ERR=0.
- Without the macro: RSP_ERR is tied 0, ADDR[1:0] are passed to ABUS unchecked, and writes never respond.

Test Plan:
1. INIT held 2 cycles, then released -> ABUS=0, WE=0, DBUS=Z, BUSY=0, REQ_READY=1.
2. Write 0xFFFFF104 <- 0x000003E8 -> exactly one cycle with ABUS=0xFFFFF104, WE=1, DBUS=0x000003E8; no RSP_VALID; a bus-model register reads back 0x3E8.
3. Read 0xFFFFF104 with RD_LAT=1, responder drives 0x000003E8 -> ABUS held 1 cycle with WE=0, DBUS released by the initiator; RSP_VALID pulses the next cycle with RSP_RDATA=0x000003E8.
4. Push W(0x100<-0xA), W(0x104<-0xB), R(0x100) with DEPTH=2 -> REQ_READY=0 after two pushes; writes appear back-to-back with no bubble; read returns 0xA; total bus cycles = 2 + RD_LAT.
5. INIT asserted during a READ cycle with RD_LAT=3 -> no RSP_VALID; FIFO empty; ABUS=IDLE_ADDR, WE=0 on the next edge.
6. With MEM_BUS_ALIGN_CHECK_EN, read 0xFFFFF102 -> no bus activity; RSP_VALID=1 and RSP_ERR=1 one cycle after pop; RSP_RDATA unchanged.
